// File: rtl/jump_target_pipe.sv
// -----------------------------------------------------------------------------
// jump_target_pipe
//
// Two-stage next-PC target generator placed between decode and the PC mux.
// Stage 1 captures the request; the target is computed from the stage-1
// registers and captured in stage 2, which drives the outputs directly.
// Observable latency is exactly two clocks, and throughput is one result per
// clock while out_ready is high.
//
// Modes (in_mode):
//   00 region jump : upper bits of pc+4 kept, low bits replaced by index<<SHIFT
//   01 branch      : pc+4 + (sign_extend(imm) << SHIFT), wraps silently
//   10 register    : in_reg passed through unchanged
//   11 sequential  : pc+4
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   flush           synchronous kill of both stages; a same-cycle input is dropped
//   in_valid/ready  request handshake; in_mode, in_pc, in_index, in_imm, in_reg
//   out_valid/ready result handshake; out_target, out_mode
//   out_misalign    (JUMP_TARGET_ALIGN_CHECK_EN only) mode 10 operand not
//                   aligned to 2^SHIFT bytes; out_target still carries in_reg
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Data is held stable while valid && !ready. ready never depends on the
// matching valid of the same interface.
//
// Optional feature macro: JUMP_TARGET_ALIGN_CHECK_EN.
// Parameter legality: INDEX_W + SHIFT < ADDR_W and IMM_W < ADDR_W.
// -----------------------------------------------------------------------------
module jump_target_pipe #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 26,
   parameter int IMM_W   = 16,
   parameter int SHIFT   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_mode,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [INDEX_W-1:0] in_index,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic [ADDR_W-1:0] in_reg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_target,
   output logic [1:0]        out_mode
`ifdef JUMP_TARGET_ALIGN_CHECK_EN
   ,
   output logic              out_misalign
`endif
);

   // Bits of pc+4 replaced by a region jump, and the byte-offset bits that
   // must be zero for an aligned register target.
   localparam logic [ADDR_W-1:0] REGION_MASK = (ADDR_W'(1) << (INDEX_W + SHIFT)) - ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ALIGN_MASK  = (ADDR_W'(1) << SHIFT) - ADDR_W'(1);

   // Stage 1 request registers
   logic               s1_valid;
   logic [1:0]         s1_mode;
   logic [ADDR_W-1:0]  s1_pc;
   logic [INDEX_W-1:0] s1_index;
   logic [IMM_W-1:0]   s1_imm;
   logic [ADDR_W-1:0]  s1_reg;

   // Stage 2 result registers
   logic               s2_valid;
   logic [ADDR_W-1:0]  s2_target;
   logic [1:0]         s2_mode;

   logic               s2_accept;
   logic [ADDR_W-1:0]  pc4;
   logic [ADDR_W-1:0]  imm_ofs;
   logic [ADDR_W-1:0]  target;

   assign s2_accept = !s2_valid || out_ready;
   assign in_ready  = !s1_valid || s2_accept;

   // Target arithmetic from the stage-1 registers; all sums wrap mod 2^ADDR_W.
   assign pc4     = s1_pc + ADDR_W'(4);
   assign imm_ofs = {{(ADDR_W - IMM_W){s1_imm[IMM_W-1]}}, s1_imm} << SHIFT;

   always_comb begin
      target = pc4;
      case (s1_mode)
         2'b00:   target = (pc4 & ~REGION_MASK) | (ADDR_W'(s1_index) << SHIFT);
         2'b01:   target = pc4 + imm_ofs;
         2'b10:   target = s1_reg;
         default: target = pc4;
      endcase
   end

   // Stage 1: loads on every input transfer; otherwise empties once its entry
   // moves into stage 2. Flush drops both the held entry and any new input.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_mode  <= 2'b00;
         s1_pc    <= '0;
         s1_index <= '0;
         s1_imm   <= '0;
         s1_reg   <= '0;
      end else if (flush) begin
         s1_valid <= 1'b0;
      end else if (in_valid && in_ready) begin
         s1_valid <= 1'b1;
         s1_mode  <= in_mode;
         s1_pc    <= in_pc;
         s1_index <= in_index;
         s1_imm   <= in_imm;
         s1_reg   <= in_reg;
      end else if (s2_accept) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: result data only changes when a new entry arrives, so a stalled
   // result stays stable. Flush clears valid but leaves the data untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid  <= 1'b0;
         s2_target <= '0;
         s2_mode   <= 2'b00;
      end else if (flush) begin
         s2_valid  <= 1'b0;
      end else if (s2_accept) begin
         s2_valid  <= s1_valid;
         if (s1_valid) begin
            s2_target <= target;
            s2_mode   <= s1_mode;
         end
      end
   end

   assign out_valid  = s2_valid;
   assign out_target = s2_target;
   assign out_mode   = s2_mode;

`ifdef JUMP_TARGET_ALIGN_CHECK_EN
   logic s2_misalign;
   logic misalign;

   // Only register jumps can be misaligned; the other modes build aligned
   // targets from aligned pc values or shifted fields.
   assign misalign = (s1_mode == 2'b10) && ((s1_reg & ALIGN_MASK) != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         s2_misalign <= 1'b0;
      end else if (!flush && s2_accept && s1_valid) begin
         s2_misalign <= misalign;
      end
   end

   assign out_misalign = s2_misalign;
`endif

endmodule
